// File: rtl/curve448_pkg.sv
// curve448_pkg: shared widths, host FSM states and word slicing helper
package curve448_pkg;
   localparam int WORD_W     = 56;
   localparam int NUM_WORDS  = 8;
   localparam int BIT_NUMBER = 448;
   localparam int VEC_W      = WORD_W * NUM_WORDS;

   typedef enum logic [2:0] {IDLE, CLR, LOAD, WAIT, COLLECT, DONE, FAIL} state_t;

   function automatic logic [WORD_W-1:0] word_sel(input logic [VEC_W-1:0] v, input logic [2:0] idx);
      return v[int'(idx)*WORD_W +: WORD_W];
   endfunction
endpackage

// File: rtl/curve448_word_deser.sv
// curve448_word_deser: 8x56 shadow capture register with indexed load and clear
module curve448_word_deser
   import curve448_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              load,
   input  logic [2:0]        idx,
   input  logic [WORD_W-1:0] din,
   output logic [VEC_W-1:0]  words_next
);
   logic [VEC_W-1:0] words_d, words_q;

   // next shadow contents, including the word being captured this cycle
   always_comb begin
      words_d = words_q;
      if (clr) words_d = '0;
      else if (load) words_d[int'(idx)*WORD_W +: WORD_W] = din;
   end

   // shadow storage, wiped by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) words_q <= '0;
      else words_q <= words_d;
   end

   assign words_next = words_d;
endmodule

// File: rtl/curve448_bus_host.sv
// curve448_bus_host: serialises scalar/u onto the ladder iterator bus and collects its 448-bit result
module curve448_bus_host
   import curve448_pkg::*;
#(
   parameter int TIMEOUT = 2000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [VEC_W-1:0]  scalar,
   input  logic [VEC_W-1:0]  u_in,
   output logic              busy,
   output logic [VEC_W-1:0]  result,
   output logic              result_valid,
   output logic              result_error,
   output logic              it_enable,
   output logic              it_reset,
   output logic [WORD_W-1:0] it_bus_input,
   output logic [8:0]        it_bit_number,
   input  logic [WORD_W-1:0] it_bus_output,
   input  logic              it_done,
   input  logic              it_error
);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d, cnt_inc;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [VEC_W-1:0]  scalar_q, scalar_d, u_q, u_d, result_q, result_d, shadow_next;
   logic [WORD_W-1:0] bus_q, bus_d;
   logic              busy_q, busy_d, valid_q, valid_d, error_q, error_d;
   logic              en_q, en_d, itrst_q, itrst_d;
   logic              des_clr, des_load;
   logic [2:0]        des_idx;

   assign cnt_inc = cnt_q + 4'd1;

   curve448_word_deser u_deser (
      .clk       (clk),
      .reset     (reset),
      .clr       (des_clr),
      .load      (des_load),
      .idx       (des_idx),
      .din       (it_bus_output),
      .words_next(shadow_next)
   );

   // next state, operand mux and registered output values for the state being entered
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tmo_d    = tmo_q;
      scalar_d = scalar_q;
      u_d      = u_q;
      result_d = result_q;
      bus_d    = '0;
      des_clr  = 1'b0;
      des_load = 1'b0;
      des_idx  = cnt_q[2:0];
      case (state_q)
         IDLE: if (start) begin
            state_d  = CLR;
            scalar_d = scalar;
            u_d      = u_in;
         end
         CLR: begin
            state_d = LOAD;
            cnt_d   = '0;
            des_clr = 1'b1;
            bus_d   = word_sel(scalar_q, 3'd0);
         end
         LOAD: if (cnt_q == 4'd15) begin
            state_d = WAIT;
            tmo_d   = '0;
         end else begin
            cnt_d = cnt_inc;
            bus_d = cnt_inc[3] ? word_sel(u_q, cnt_inc[2:0]) : word_sel(scalar_q, cnt_inc[2:0]);
         end
         WAIT: if (it_error) state_d = FAIL;
         else if (it_done) begin
            state_d  = COLLECT;
            cnt_d    = 4'd1;
            des_load = 1'b1;
            des_idx  = 3'd0;
         end else if (tmo_q == TW'(TIMEOUT - 1)) state_d = FAIL;
         else tmo_d = tmo_q + TW'(1);
         COLLECT: if (it_error) state_d = FAIL;
         else begin
            des_load = 1'b1;
            if (cnt_q == 4'd7) begin
               state_d  = DONE;
               result_d = shadow_next;
            end else cnt_d = cnt_inc;
         end
         DONE:    state_d = IDLE;
         FAIL:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d  = state_d != IDLE;
      en_d    = state_d inside {LOAD, WAIT, COLLECT};
      itrst_d = state_d inside {IDLE, CLR};
      valid_d = state_d == DONE;
      error_d = state_d == FAIL;
   end

   // state and output registers, all returned to idle values by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         tmo_q    <= '0;
         scalar_q <= '0;
         u_q      <= '0;
         result_q <= '0;
         bus_q    <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
         en_q     <= 1'b0;
         itrst_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tmo_q    <= tmo_d;
         scalar_q <= scalar_d;
         u_q      <= u_d;
         result_q <= result_d;
         bus_q    <= bus_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         error_q  <= error_d;
         en_q     <= en_d;
         itrst_q  <= itrst_d;
      end
   end

   assign busy          = busy_q;
   assign result        = result_q;
   assign result_valid  = valid_q;
   assign result_error  = error_q;
   assign it_enable     = en_q;
   assign it_reset      = itrst_q;
   assign it_bus_input  = bus_q;
   assign it_bit_number = 9'(BIT_NUMBER);
endmodule

// File: doc/curve448_bus_host.md
Name: curve448_bus_host

Overview:
- Host-side controller for the Curve448 ladder iterator's 56-bit word bus.
- Takes a 448-bit scalar and a 448-bit u-coordinate, serialises them as 56-bit words onto the iterator bus input, and holds iterator enable high.
- Waits for iterator done, then deserialises the 8-word result from the iterator bus output.
- Reports the assembled result or an error: iterator error flag or timeout.

Parameters:
- WORD_W, 56, bus word width
- NUM_WORDS, 8, words per 448-bit operand
- BIT_NUMBER, 448, ladder bit count driven on it_bit_number
- TIMEOUT, 2000000, max cycles to wait for it_done before error

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request pulse; sampled only in IDLE
- scalar  in  448  scalar k; word i = scalar[56i+55:56i]
- u_in  in  448  input u-coordinate; same word order
- busy  out  1  high in every state except IDLE
- result  out  448  assembled result; word i at [56i+55:56i]
- result_valid  out  1  one-cycle pulse when result is updated
- result_error  out  1  one-cycle pulse, mutually exclusive with result_valid
- it_enable  out  1  to iterator enable
- it_reset  out  1  to iterator reset (active-high)
- it_bus_input  out  56  to iterator bus_input
- it_bit_number  out  9  to iterator bit_number_initial_value; constant BIT_NUMBER
- it_bus_output  in  56  from iterator bus_output
- it_done  in  1  from iterator done
- it_error  in  1  from iterator error

Behaviour:
- Reset (reset=0, async):
  - State IDLE; busy=0, result=0, result_valid=0, result_error=0.
  - it_enable=0, it_reset=1, it_bus_input=0; word counter=0, timeout counter=0.
- All outputs are registered.
- FSM states:
  - IDLE: it_reset=1, it_enable=0.
    - On start=1: latch scalar and u_in into internal registers; go to CLR.
  - CLR: one cycle; it_reset=1; go to LOAD with counter=0.
  - LOAD: 16 cycles; it_reset=0, it_enable=1.
    - Counter 0..7 drives scalar word[counter]; counter 8..15 drives u word[counter-8]; LSW first.
    - After counter=15: go to WAIT; it_bus_input=0; timeout counter cleared.
  - WAIT: it_enable stays 1; timeout counter increments each cycle.
    - it_error=1: go to FAIL. Error wins over done in the same cycle.
    - Else it_done=1: capture it_bus_output as result word 0 in that same cycle; go to COLLECT with counter=1.
    - Timeout counter reaches TIMEOUT-1 without done: go to FAIL.
  - COLLECT: capture it_bus_output into word[counter] each cycle, counter 1..7.
    - it_error=1 during COLLECT: go to FAIL; result register is not updated.
    - After word 7: go to DONE.
  - DONE: result register ← collected shadow words; result_valid=1 for one cycle; go to IDLE.
  - FAIL: result_error=1 for one cycle; result keeps its previous value; go to IDLE.
- Result is assembled in a shadow register, so `result` changes only in DONE.
- Latency from start to first bus word: 2 cycles (CLR, then the LOAD first cycle registered).
- start while busy is ignored. start is not queued.
- it_done outside WAIT is ignored. it_error outside WAIT/COLLECT is ignored.
- Async reset mid-operation:
  - Immediately returns to IDLE with it_reset=1; no result_valid or result_error pulse.
  - Shadow words cleared.
- Timeout counter width is $clog2(TIMEOUT+1); no wrap before FAIL is reached.

Decomposition:
- Shared package curve448_pkg:
  - WORD_W, NUM_WORDS, BIT_NUMBER.
  - FSM state enum {IDLE, CLR, LOAD, WAIT, COLLECT, DONE, FAIL}.
  - Function word_sel(vec448, idx) returning a 56-bit slice.
- One natural sub-module: curve448_word_deser, an 8×56 shift/indexed capture register with load-enable and clear.
- The serialiser is a plain mux inside the top.

Test Plan:
- Iterator model with done after 100 cycles, result words 56'h1..56'h8; scalar=448'h5 (word0=5, others 0), u_in=448'h9 → it_bus_input sequence 5,0×7,9,0×7 while it_enable=1; result_valid pulses once; result words 1..8 in order.
- it_error asserted 50 cycles into WAIT → result_error one-cycle pulse; result unchanged (0 after reset); busy drops next cycle.
- TIMEOUT=20, model never asserts done → result_error exactly 20 cycles after WAIT entry; it_reset=1 in IDLE afterwards.
- it_done and it_error asserted in the same WAIT cycle → FAIL path: result_error=1, result_valid stays 0.
- reset pulled low during COLLECT word 4 → all outputs at reset values asynchronously, no pulse. Then start again → full transfer completes with correct result.
- start held high for 3 cycles and again during WAIT → exactly one transfer; second start ignored, verified by a single result_valid pulse.
